adc_capture_mux: RTL and testbench
==================================

Name: adc_capture_mux

Overview:
Parametrised successor to the receive-path ADC input latch. It captures raw ADC samples or the TX loopback word and optionally removes the ADC output randomizer (XOR of bits [W-1:1] with bit 0). It switches sources glitch-free with a blanking interval, rounds and saturates the loopback slice, and flags clipping with a sticky overload bit. It also reports windowed peak magnitude. It sits between the ADC pins/IDDR and the DDC input in the clk_i (ADC sample clock) domain.

Parameters:
ADC_W, 16, ADC sample width and data_out width (two's complement).
LB_W, 27, TX loopback word width; must be greater than ADC_W.
BLANK_CYC, 8, output-zero cycles after a source change (1..255).
PEAK_LOG2, 16, peak window length = 2^PEAK_LOG2 valid samples.

Ports:
clk_i  in  1  sample clock; all logic rising-edge.
rst_i  in  1  synchronous reset, active-high.
data_in_adc  in  ADC_W  raw ADC word.
data_in_tx_loopback  in  LB_W  TX DAC-path word.
source  in  1  0 = ADC, 1 = loopback.
rand_en  in  1  1 = apply derandomizer to ADC path.
ovf_clr  in  1  clears sticky overload flag.
data_out  out  ADC_W  selected, conditioned sample.
data_valid  out  1  data_out carries a real sample.
source_active  out  1  source currently driving data_out.
ovf_o  out  1  sticky ADC clip flag.
peak_o  out  ADC_W-1  last completed window peak |x|.
peak_stb  out  1  one-cycle pulse when peak_o updates.

Behaviour:
- Reset (rst_i=1 at edge): data_out=0, data_valid=0, source_active=0, ovf_o=0, peak_o=0, peak_stb=0, FSM=RUN_ADC, pipeline regs=0, peak tracker=0, window counter=0. Reset mid-blank or mid-window abandons it.
- Pipeline: S1 registers data_in_adc, data_in_tx_loopback, source, rand_en. S2 conditions and registers data_out. Latency is 2 clocks from input to data_out; rand_en and source are pipelined with the data.
- ADC path: if rand_en, bit0 is passed through and bits[ADC_W-1:1] are each XORed with bit0; otherwise the word passes unchanged.
- Loopback path: take LB_W[LB_W-1 -: ADC_W] and add round bit LB_W[LB_W-ADC_W-1] (round half up). If the result exceeds the max positive value, saturate to 2^(ADC_W-1)-1. No negative overflow is possible.
- FSM states RUN_ADC, RUN_LB, BLANK. source_active reflects the RUN state, or the target source during BLANK.
- In a RUN state, if S1 source differs from the current state: enter BLANK, load counter=BLANK_CYC, target=S1 source.
- BLANK: data_out=0, data_valid=0; counter decrements each clock. At 1, go to RUN_<target>; the next output is a valid sample from the new source.
- Source toggles during BLANK: if the new value differs from target, update target and reload counter=BLANK_CYC. A glitch back to the original source still completes a full blank.
- data_valid=1 in every RUN-state cycle after the first post-reset S2 fill (2 cycles).
- Overload: set ovf_o when a valid ADC-path sample (after derandomize) equals 2^(ADC_W-1)-1 or -2^(ADC_W-1). Loopback samples never set it. ovf_clr clears it. If clr and a set happen in the same cycle, set wins.
- Peak: magnitude is |data_out|, with -2^(ADC_W-1) mapped to 2^(ADC_W-1)-1, so it fits in ADC_W-1 bits. The tracker keeps the max over valid samples only, and the window counter counts valid samples only.
- At the 2^PEAK_LOG2-th valid sample: peak_o = max(tracker, current mag), peak_stb=1 for one cycle, tracker reloads to 0, counter wraps to 0.
- A source change does not reset the peak window.

Test Plan:
- Derandomize: rand_en=1, source=0, adc=16'h0003 → data_out=16'hFFFD two cycles later, data_valid=1. rand_en=0 with the same input → 16'h0003.
- Loopback round/saturate: source=1 after blank, lb=27'h0000_7FF → 16'h0001. lb=27'h3FF_FFFF (max positive, round bit set) → 16'h7FFF, ovf_o stays 0.
- Source switch: toggle source 0→1 with BLANK_CYC=8 → exactly 8 cycles of data_out=0/data_valid=0, then loopback samples. Toggle back at blank cycle 4 → blank restarts; total blank is 12 cycles.
- Overload: ADC sample 16'h8000 → ovf_o=1 and holds. ovf_clr pulse → 0. ovf_clr coincident with 16'h7FFF → ovf_o stays 1.
- Peak: PEAK_LOG2=2, valid samples {100,-300,16'h8000,5} → peak_stb once, peak_o=15'h7FFF. The next window {1,2,3,-4} → peak_o=4.
- Reset mid-operation: assert rst_i during BLANK and with ovf_o=1 → all outputs 0 the next cycle, FSM=RUN_ADC, first valid ADC sample 2 cycles after release.

Source files
------------

// File: rtl/adc_capture_mux.sv
// ADC / TX-loopback capture stage ahead of the DDC: optional derandomizer, glitch-free
// source switching with output blanking, loopback round/saturate, sticky clip flag, windowed peak.
module adc_capture_mux #(
    parameter int ADC_W     = 16,
    parameter int LB_W      = 27,
    parameter int BLANK_CYC = 8,
    parameter int PEAK_LOG2 = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADC_W-1:0]  data_in_adc,
    input  logic [LB_W-1:0]   data_in_tx_loopback,
    input  logic              source,
    input  logic              rand_en,
    input  logic              ovf_clr,
    output logic [ADC_W-1:0]  data_out,
    output logic              data_valid,
    output logic              source_active,
    output logic              ovf_o,
    output logic [ADC_W-2:0]  peak_o,
    output logic              peak_stb
);

    typedef enum logic [1:0] {
        RUN_ADC,
        RUN_LB,
        BLANK
    } state_t;

    localparam logic [ADC_W-1:0] MAX_POS   = {1'b0, {(ADC_W-1){1'b1}}};
    localparam logic [ADC_W-1:0] MIN_NEG   = {1'b1, {(ADC_W-1){1'b0}}};
    localparam logic [7:0]       BLANK_LEN = 8'(BLANK_CYC);

    state_t                state_q;
    logic [ADC_W-1:0]      adc_q;
    logic [ADC_W:0]        lbSlice_q;
    logic                  src_q;
    logic                  rand_q;
    logic                  fill_q;
    logic [7:0]            blankCnt_q;
    logic                  target_q;
    logic                  active_q;
    logic [ADC_W-1:0]      dataOut_q;
    logic                  valid_q;
    logic                  ovf_q;
    logic [ADC_W-2:0]      tracker_q;
    logic [ADC_W-2:0]      peak_q;
    logic                  peakStb_q;
    logic [PEAK_LOG2-1:0]  winCnt_q;

    logic [ADC_W-1:0]      adcCond;
    logic [ADC_W-1:0]      lbTop;
    logic                  lbRound;
    logic [ADC_W-1:0]      lbCond;
    logic                  emit;
    logic                  valid_d;
    logic [ADC_W-1:0]      dataOut_d;
    logic [ADC_W-1:0]      negData;
    logic [ADC_W-2:0]      mag;
    logic [ADC_W-2:0]      peakMax;
    logic                  ovfSet;

    // Only the top ADC_W bits plus the round bit of the loopback word are ever needed.
    if (LB_W > ADC_W + 1) begin : gDiscard
        logic unusedLbBits;
        assign unusedLbBits = ^data_in_tx_loopback[LB_W-ADC_W-2:0];
    end

    always_comb begin
        adcCond   = rand_q ? {adc_q[ADC_W-1:1] ^ {(ADC_W-1){adc_q[0]}}, adc_q[0]} : adc_q;
        lbTop     = lbSlice_q[ADC_W:1];
        lbRound   = lbSlice_q[0];
        lbCond    = (lbTop == MAX_POS && lbRound) ? MAX_POS
                                                  : lbTop + {{(ADC_W-1){1'b0}}, lbRound};
        // A sample is emitted when running on the matching source, or on the last blank cycle.
        emit      = ((state_q == RUN_ADC) && !src_q) ||
                    ((state_q == RUN_LB)  &&  src_q) ||
                    ((state_q == BLANK) && (src_q == target_q) && (blankCnt_q == 8'd1));
        valid_d   = emit && fill_q;
        dataOut_d = valid_d ? (src_q ? lbCond : adcCond) : '0;
        ovfSet    = valid_d && !src_q && (adcCond == MAX_POS || adcCond == MIN_NEG);
        negData   = -dataOut_d;
        if (!dataOut_d[ADC_W-1]) begin
            mag = dataOut_d[ADC_W-2:0];
        end else if (dataOut_d == MIN_NEG) begin
            mag = {(ADC_W-1){1'b1}};
        end else begin
            mag = negData[ADC_W-2:0];
        end
        peakMax   = (mag > tracker_q) ? mag : tracker_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN_ADC;
            adc_q      <= '0;
            lbSlice_q  <= '0;
            src_q      <= 1'b0;
            rand_q     <= 1'b0;
            fill_q     <= 1'b0;
            blankCnt_q <= '0;
            target_q   <= 1'b0;
            active_q   <= 1'b0;
            dataOut_q  <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            tracker_q  <= '0;
            peak_q     <= '0;
            peakStb_q  <= 1'b0;
            winCnt_q   <= '0;
        end else begin
            adc_q     <= data_in_adc;
            lbSlice_q <= data_in_tx_loopback[LB_W-1 -: ADC_W+1];
            src_q     <= source;
            rand_q    <= rand_en;
            fill_q    <= 1'b1;

            case (state_q)
                RUN_ADC, RUN_LB: begin
                    if (src_q != (state_q == RUN_LB)) begin
                        state_q    <= BLANK;
                        blankCnt_q <= BLANK_LEN;
                        target_q   <= src_q;
                        active_q   <= src_q;
                    end
                end
                BLANK: begin
                    // Any change of heart restarts the full blanking interval.
                    if (src_q != target_q) begin
                        target_q   <= src_q;
                        active_q   <= src_q;
                        blankCnt_q <= BLANK_LEN;
                    end else if (blankCnt_q == 8'd1) begin
                        state_q <= target_q ? RUN_LB : RUN_ADC;
                    end else begin
                        blankCnt_q <= blankCnt_q - 8'd1;
                    end
                end
                default: state_q <= RUN_ADC;
            endcase

            dataOut_q <= dataOut_d;
            valid_q   <= valid_d;

            if (ovfSet) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end

            peakStb_q <= 1'b0;
            if (valid_d) begin
                if (&winCnt_q) begin
                    peak_q    <= peakMax;
                    peakStb_q <= 1'b1;
                    tracker_q <= '0;
                    winCnt_q  <= '0;
                end else begin
                    tracker_q <= peakMax;
                    winCnt_q  <= winCnt_q + PEAK_LOG2'(1);
                end
            end
        end
    end

    assign data_out      = dataOut_q;
    assign data_valid    = valid_q;
    assign source_active = active_q;
    assign ovf_o         = ovf_q;
    assign peak_o        = peak_q;
    assign peak_stb      = peakStb_q;

endmodule

// File: tb/tb_adc_capture_mux.sv
// Directed bench for adc_capture_mux: derandomizer, loopback rounding, blanking,
// overload flag, reset behaviour and windowed peak with a 4-sample window.
module tb_adc_capture_mux;

    localparam int ADC_W     = 16;
    localparam int LB_W      = 27;
    localparam int BLANK_CYC = 8;
    localparam int PEAK_LOG2 = 2;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [ADC_W-1:0]  data_in_adc = '0;
    logic [LB_W-1:0]   data_in_tx_loopback = '0;
    logic              source = 1'b0;
    logic              rand_en = 1'b0;
    logic              ovf_clr = 1'b0;
    logic [ADC_W-1:0]  data_out;
    logic              data_valid;
    logic              source_active;
    logic              ovf_o;
    logic [ADC_W-2:0]  peak_o;
    logic              peak_stb;

    int total = 0;
    int bad   = 0;
    int zeros = 0;

    logic [15:0] vals [8] = '{16'd100, 16'hFED4, 16'h8000, 16'd5,
                              16'd1,   16'd2,   16'd3,   16'hFFFC};

    adc_capture_mux #(
        .ADC_W(ADC_W), .LB_W(LB_W), .BLANK_CYC(BLANK_CYC), .PEAK_LOG2(PEAK_LOG2)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .data_in_adc(data_in_adc),
        .data_in_tx_loopback(data_in_tx_loopback),
        .source(source),
        .rand_en(rand_en),
        .ovf_clr(ovf_clr),
        .data_out(data_out),
        .data_valid(data_valid),
        .source_active(source_active),
        .ovf_o(ovf_o),
        .peak_o(peak_o),
        .peak_stb(peak_stb)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] adc, input logic [26:0] lb,
                                 input logic src, input logic rnd, input logic clr);
        data_in_adc         = adc;
        data_in_tx_loopback = lb;
        source              = src;
        rand_en             = rnd;
        ovf_clr             = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_data"},   32'(data_out), 32'h0);
        checkOutput({tag, "_valid"},  32'(data_valid), 32'h0);
        checkOutput({tag, "_active"}, 32'(source_active), 32'h0);
        checkOutput({tag, "_ovf"},    32'(ovf_o), 32'h0);
        checkOutput({tag, "_peak"},   32'(peak_o), 32'h0);
        checkOutput({tag, "_stb"},    32'(peak_stb), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset state
        applyStimulus(16'h0000, 27'h0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;
        tick();
        tick();
        checkAllZero("reset");

        // Derandomizer on, then off
        rst_i = 1'b0;
        applyStimulus(16'h0003, 27'h0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("fill_valid", 32'(data_valid), 32'h0);
        tick();
        checkOutput("derand_data", 32'(data_out), 32'hFFFD);
        checkOutput("derand_valid", 32'(data_valid), 32'h1);
        checkOutput("derand_active", 32'(source_active), 32'h0);
        applyStimulus(16'h0003, 27'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("raw_data", 32'(data_out), 32'h0003);

        // Switch to loopback: exactly BLANK_CYC zero cycles
        applyStimulus(16'h0003, 27'h00007FF, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("blank_data", 32'(data_out), 32'h0);
            checkOutput("blank_valid", 32'(data_valid), 32'h0);
            if (i == 0) checkOutput("blank_active", 32'(source_active), 32'h1);
        end
        tick();
        checkOutput("lb_round_data", 32'(data_out), 32'h0001);
        checkOutput("lb_round_valid", 32'(data_valid), 32'h1);
        checkOutput("lb_active", 32'(source_active), 32'h1);
        applyStimulus(16'h0003, 27'h3FFFFFF, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("lb_sat_data", 32'(data_out), 32'h7FFF);
        checkOutput("lb_sat_ovf", 32'(ovf_o), 32'h0);

        // Glitch back during blank restarts the interval
        applyStimulus(16'h0003, 27'h3FFFFFF, 1'b0, 1'b0, 1'b0);
        tick();
        zeros = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (!data_valid) zeros++;
            if (i == 0) checkOutput("glitch_active", 32'(source_active), 32'h0);
        end
        applyStimulus(16'h0003, 27'h3FFFFFF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (data_valid) break;
            zeros++;
        end
        checkOutput("glitch_blank_len", 32'(zeros), 32'd12);
        checkOutput("glitch_valid", 32'(data_valid), 32'h1);
        checkOutput("glitch_data", 32'(data_out), 32'h7FFF);
        checkOutput("glitch_active_end", 32'(source_active), 32'h1);

        // Back to ADC, overload set/hold/clear/set-wins
        applyStimulus(16'h1234, 27'h3FFFFFF, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 30; i++) begin
            tick();
            if (data_valid) break;
        end
        checkOutput("adc_back_data", 32'(data_out), 32'h1234);
        checkOutput("adc_back_active", 32'(source_active), 32'h0);
        checkOutput("adc_back_ovf", 32'(ovf_o), 32'h0);
        applyStimulus(16'h8000, 27'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("ovf_min_data", 32'(data_out), 32'h8000);
        checkOutput("ovf_set", 32'(ovf_o), 32'h1);
        applyStimulus(16'h0001, 27'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("ovf_hold", 32'(ovf_o), 32'h1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checkOutput("ovf_clear", 32'(ovf_o), 32'h0);
        applyStimulus(16'h8000, 27'h0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(16'h7FFF, 27'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("ovf_reset_again", 32'(ovf_o), 32'h1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checkOutput("ovf_max_data", 32'(data_out), 32'h7FFF);
        checkOutput("ovf_set_wins", 32'(ovf_o), 32'h1);

        // Reset while blanking with overload set
        applyStimulus(16'h7FFF, 27'h3FFFFFF, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("preRst_valid", 32'(data_valid), 32'h0);
        checkOutput("preRst_active", 32'(source_active), 32'h1);
        checkOutput("preRst_ovf", 32'(ovf_o), 32'h1);
        rst_i = 1'b1;
        tick();
        checkAllZero("midRst");
        rst_i = 1'b0;
        applyStimulus(16'h0042, 27'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("postRst_fill", 32'(data_valid), 32'h0);
        tick();
        checkOutput("postRst_data", 32'(data_out), 32'h0042);
        checkOutput("postRst_valid", 32'(data_valid), 32'h1);
        checkOutput("postRst_active", 32'(source_active), 32'h0);

        // Peak windows of four valid samples
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        applyStimulus(vals[0], 27'h0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i < 7) applyStimulus(vals[i+1], 27'h0, 1'b0, 1'b0, 1'b0);
            tick();
            checkOutput("peak_seq_data", 32'(data_out), 32'(vals[i]));
            checkOutput("peak_stb", 32'(peak_stb), (i == 3 || i == 7) ? 32'h1 : 32'h0);
            if (i == 2) checkOutput("peak_initial", 32'(peak_o), 32'h0);
            if (i == 3) checkOutput("peak_win1", 32'(peak_o), 32'h7FFF);
            if (i == 6) checkOutput("peak_hold", 32'(peak_o), 32'h7FFF);
            if (i == 7) checkOutput("peak_win2", 32'(peak_o), 32'h0004);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
